note_lane_scroller: RTL and testbench

Parametrised falling-note display generator for the VGA path. It records which of `LANES` note lanes were active in each scroll period into a circular row buffer, and renders them as blocks falling down lanes over a pitch-shifted gradient background. It also draws a hit bar showing live key state. It sits between the key/note decoder and the VGA timing/colour mux, replacing the fixed 7-lane free-mode renderer.

---
 rtl/note_disp_pkg.sv | 14 +
 rtl/lane_row_ram.sv | 22 ++
 rtl/note_lane_scroller.sv | 163 ++++++++++++++++
 tb/tb_note_lane_scroller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/note_disp_pkg.sv
// Shared encodings, default colours and control states for the falling-note display.
package note_disp_pkg;

    localparam logic [1:0]  SHIFT_HIGH            = 2'b10;
    localparam logic [1:0]  SHIFT_LOW             = 2'b01;

    localparam logic [23:0] DEF_BLOCK_COLOR       = 24'h000000;
    localparam logic [23:0] DEF_HIT_ON_COLOR      = 24'hFF0000;
    localparam logic [23:0] DEF_HIT_OFF_COLOR     = 24'h808080;
    localparam logic [23:0] BG_WHITE              = 24'hFFFFFF;

    typedef enum logic {IDLE, CLEAR} ctrl_state_t;

endpackage

// File: rtl/lane_row_ram.sv
// History row storage: one write port, one synchronous read-first read port, no reset.
module lane_row_ram #(
    parameter int LANES = 7,
    parameter int DEPTH = 192,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [LANES-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [LANES-1:0] rdata
);

    logic [LANES-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/note_lane_scroller.sv
// Falling-note lane renderer: accumulates key activity per scroll period into a row
// history and draws it as blocks over a pitch-shifted gradient, with a live hit bar.
module note_lane_scroller
    import note_disp_pkg::*;
#(
    parameter int          LANES         = 7,
    parameter int          LANE_W        = 32,
    parameter int          LANE_PITCH    = 64,
    parameter int          X0            = 112,
    parameter int          DEPTH         = 192,
    parameter int          ROW_SH        = 1,
    parameter int          HIT_Y         = 400,
    parameter int          HIT_H         = 16,
    parameter int          PERIOD        = 100000,
    parameter logic [23:0] BLOCK_COLOR   = DEF_BLOCK_COLOR,
    parameter logic [23:0] HIT_ON_COLOR  = DEF_HIT_ON_COLOR,
    parameter logic [23:0] HIT_OFF_COLOR = DEF_HIT_OFF_COLOR
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic [LANES-1:0] note,
    input  logic [1:0]       shift,
    input  logic             pause,
    input  logic             clear,
    output logic [23:0]      pos_data,
    output logic             busy,
    output logic             tick
);

    localparam int ROW_H  = 1 << ROW_SH;
    localparam int PLAY_H = DEPTH * ROW_H;
    localparam int AW     = (DEPTH > 1)  ? $clog2(DEPTH)  : 1;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LW     = (LANES > 1)  ? $clog2(LANES)  : 1;

    function automatic logic [23:0] bg_color(input logic [9:0] y, input logic [1:0] s);
        logic [11:0] q;
        logic [7:0]  t;
        q = (({2'b00, y} * 12'd2) / 12'd3) - 12'd1;
        t = q[7:0];
        case (s)
            SHIFT_HIGH: bg_color = {t, t, 8'hFF};
            SHIFT_LOW:  bg_color = {8'hFF, t, t};
            default:    bg_color = BG_WHITE;
        endcase
    endfunction

    ctrl_state_t      state;
    logic [AW-1:0]    head, head_nxt, clr_addr;
    logic [CW-1:0]    count;
    logic [LANES-1:0] acc, row;
    logic             wrap;

    assign busy     = (state == CLEAR);
    assign wrap     = (count == CW'(PERIOD - 1));
    assign tick     = wrap && !pause && !busy;
    assign head_nxt = (head == AW'(DEPTH - 1)) ? '0 : head + 1'b1;
    assign row      = acc | note;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            head     <= '0;
            count    <= '0;
            acc      <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    acc <= '0;
                    if (clr_addr == AW'(DEPTH - 1)) begin
                        state    <= IDLE;
                        clr_addr <= '0;
                        head     <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    acc <= tick ? '0 : row;
                    if (!pause) count <= wrap ? '0 : count + 1'b1;
                    if (tick)   head  <= head_nxt;
                    if (clear) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
            endcase
        end
    end

    // The sweep and the scroll share the single write port; busy excludes ticks.
    logic             ram_we;
    logic [AW-1:0]    ram_waddr, rd_addr;
    logic [LANES-1:0] ram_wdata, ram_rdata;

    assign ram_we    = busy | tick;
    assign ram_waddr = busy ? clr_addr : head_nxt;
    assign ram_wdata = busy ? '0 : row;

    lane_row_ram #(.LANES(LANES), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (vga_clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    int          px, py, r, h;
    logic        lane_hit, in_play, in_bar;
    logic [LW-1:0] lane_idx;

    assign px = int'(pos_x);
    assign py = int'(pos_y);
    assign r  = py >> ROW_SH;
    assign h  = int'(head);

    always_comb begin
        lane_hit = 1'b0;
        lane_idx = '0;
        for (int i = 0; i < LANES; i++) begin
            if (px >= X0 + i * LANE_PITCH && px < X0 + i * LANE_PITCH + LANE_W) begin
                lane_hit = 1'b1;
                lane_idx = LW'(i);
            end
        end
        in_play = (py < PLAY_H);
        in_bar  = (py >= HIT_Y) && (py < HIT_Y + HIT_H);
        rd_addr = (r <= h) ? AW'(h - r) : AW'(h + DEPTH - r);
    end

    // Stage 1: geometry, region flags, live key and background; RAM read in flight.
    logic          lane_hit_p1, play_p1, bar_p1, key_p1, busy_p1;
    logic [LW-1:0] lane_idx_p1;
    logic [23:0]   bg_p1;

    always_ff @(posedge vga_clk) begin
        lane_hit_p1 <= lane_hit;
        lane_idx_p1 <= lane_idx;
        play_p1     <= in_play;
        bar_p1      <= in_bar;
        key_p1      <= note[lane_idx];
        busy_p1     <= busy;
        bg_p1       <= bg_color(pos_y, shift);
    end

    // Stage 2: combine history bit with stage-1 flags into the final colour.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            pos_data <= '0;
        end else if (lane_hit_p1 && play_p1 && !busy_p1 && ram_rdata[lane_idx_p1]) begin
            pos_data <= BLOCK_COLOR;
        end else if (lane_hit_p1 && bar_p1) begin
            pos_data <= key_p1 ? HIT_ON_COLOR : HIT_OFF_COLOR;
        end else begin
            pos_data <= bg_p1;
        end
    end

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed bench for note_lane_scroller with a small geometry (3 lanes, 8 rows, period 4).
module tb_note_lane_scroller;

    localparam logic [23:0] BLK   = 24'h000000;
    localparam logic [23:0] ON    = 24'hFF0000;
    localparam logic [23:0] OFF   = 24'h808080;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic [9:0]  pos_x, pos_y;
    logic [2:0]  note;
    logic [1:0]  shift;
    logic        pause, clear;
    logic [23:0] pos_data;
    logic        busy, tick;

    int checks   = 0;
    int failures = 0;

    note_lane_scroller #(
        .LANES(3), .DEPTH(8), .ROW_SH(1), .PERIOD(4), .HIT_Y(20), .HIT_H(2)
    ) dut (
        .vga_clk  (vga_clk),
        .rst      (rst),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .note     (note),
        .shift    (shift),
        .pause    (pause),
        .clear    (clear),
        .pos_data (pos_data),
        .busy     (busy),
        .tick     (tick)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  nt;
        logic [1:0]  sh;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Called at a negedge; presents one pixel and samples its colour two cycles later.
    task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic [2:0] nt,
                         input logic [1:0] sh, input logic [23:0] exp, input string nm);
        pos_x = x; pos_y = y; note = nt; shift = sh;
        @(negedge vga_clk);
        @(negedge vga_clk);
        check(nm, {8'h00, pos_data}, {8'h00, exp});
    endtask

    // Runs exactly one scroll period from count 0 with a one-cycle key pulse, then re-pauses.
    task automatic do_tick(input logic [2:0] np);
        int k;
        bit seen;
        note  = 3'b000;
        pause = 1'b0;
        @(negedge vga_clk);
        note = np;
        @(negedge vga_clk);
        note = 3'b000;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 12) begin
            if (tick) seen = 1'b1;
            else begin
                @(negedge vga_clk);
                k++;
            end
        end
        check("tick_seen", {31'd0, seen}, 32'd1);
        @(posedge vga_clk);
        @(negedge vga_clk);
        pause = 1'b1;
    endtask

    initial begin
        int n;

        vecs[0]  = '{10'd112, 10'd0,   3'b000, 2'b00, BLK};
        vecs[1]  = '{10'd143, 10'd1,   3'b000, 2'b00, BLK};
        vecs[2]  = '{10'd144, 10'd0,   3'b000, 2'b00, WHITE};
        vecs[3]  = '{10'd111, 10'd0,   3'b000, 2'b00, WHITE};
        vecs[4]  = '{10'd176, 10'd0,   3'b000, 2'b00, WHITE};
        vecs[5]  = '{10'd240, 10'd0,   3'b000, 2'b10, BLK};
        vecs[6]  = '{10'd271, 10'd1,   3'b000, 2'b01, BLK};
        vecs[7]  = '{10'd272, 10'd0,   3'b000, 2'b10, WHITE};
        vecs[8]  = '{10'd112, 10'd2,   3'b000, 2'b10, 24'h0000FF};
        vecs[9]  = '{10'd180, 10'd20,  3'b010, 2'b00, ON};
        vecs[10] = '{10'd240, 10'd20,  3'b010, 2'b00, OFF};
        vecs[11] = '{10'd180, 10'd21,  3'b010, 2'b10, ON};
        vecs[12] = '{10'd180, 10'd22,  3'b010, 2'b10, 24'h0D0DFF};
        vecs[13] = '{10'd10,  10'd3,   3'b000, 2'b10, 24'h0101FF};
        vecs[14] = '{10'd10,  10'd3,   3'b000, 2'b00, WHITE};
        vecs[15] = '{10'd10,  10'd0,   3'b000, 2'b01, WHITE};
        vecs[16] = '{10'd10,  10'd3,   3'b000, 2'b01, 24'hFF0101};
        vecs[17] = '{10'd112, 10'd20,  3'b000, 2'b11, OFF};
        vecs[18] = '{10'd112, 10'd19,  3'b001, 2'b00, WHITE};
        vecs[19] = '{10'd10,  10'd300, 3'b000, 2'b10, 24'hC7C7FF};
        vecs[20] = '{10'd112, 10'd16,  3'b000, 2'b00, WHITE};
        vecs[21] = '{10'd112, 10'd21,  3'b101, 2'b00, ON};
        vecs[22] = '{10'd240, 10'd21,  3'b101, 2'b00, ON};

        rst = 1'b1; pos_x = '0; pos_y = '0; note = '0; shift = '0; pause = 1'b1; clear = 1'b0;
        repeat (3) @(negedge vga_clk);
        check("rst_pos_data", {8'h00, pos_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_tick", {31'd0, tick}, 32'd0);

        rst = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge vga_clk);
        end
        check("reset_busy_len", n, 32'd8);

        probe(10'd112, 10'd0,  3'b000, 2'b00, WHITE,       "idle_bg_lane0");
        probe(10'd240, 10'd15, 3'b000, 2'b10, 24'h0909FF,  "idle_bg_lane2");

        do_tick(3'b001);
        probe(10'd112, 10'd0, 3'b000, 2'b00, BLK,   "blk_row0_y0");
        probe(10'd112, 10'd1, 3'b000, 2'b00, BLK,   "blk_row0_y1");
        probe(10'd176, 10'd0, 3'b000, 2'b00, WHITE, "blk_lane1_empty");
        probe(10'd112, 10'd2, 3'b000, 2'b00, WHITE, "blk_row1_empty");

        n = 0;
        repeat (10) begin
            @(negedge vga_clk);
            if (tick) n++;
        end
        check("pause_ticks", n, 32'd0);
        probe(10'd112, 10'd1, 3'b000, 2'b00, BLK,   "pause_blk_kept");
        probe(10'd112, 10'd2, 3'b000, 2'b00, WHITE, "pause_row1_empty");

        repeat (7) do_tick(3'b000);
        probe(10'd112, 10'd14, 3'b000, 2'b00, BLK,   "scroll7_y14");
        probe(10'd112, 10'd15, 3'b000, 2'b00, BLK,   "scroll7_y15");
        probe(10'd112, 10'd13, 3'b000, 2'b00, WHITE, "scroll7_y13");
        probe(10'd112, 10'd0,  3'b000, 2'b00, WHITE, "scroll7_y0");

        do_tick(3'b000);
        probe(10'd112, 10'd14, 3'b000, 2'b00, WHITE, "scroll8_gone");
        probe(10'd112, 10'd0,  3'b000, 2'b00, WHITE, "scroll8_y0");

        do_tick(3'b101);
        for (int i = 0; i < 23; i++) begin
            probe(vecs[i].x, vecs[i].y, vecs[i].nt, vecs[i].sh, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        note  = 3'b000;
        clear = 1'b1;
        @(negedge vga_clk);
        clear = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            clear = (n == 3);
            @(negedge vga_clk);
        end
        clear = 1'b0;
        check("clear_busy_len", n, 32'd8);
        probe(10'd112, 10'd0, 3'b000, 2'b00, WHITE, "clear_lane0");
        probe(10'd240, 10'd1, 3'b000, 2'b00, WHITE, "clear_lane2");

        pause = 1'b0;
        repeat (2) @(negedge vga_clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd1);
        check("midrst_pos_data", {8'h00, pos_data}, 32'd0);
        check("midrst_tick", {31'd0, tick}, 32'd0);
        @(negedge vga_clk);
        rst = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge vga_clk);
        end
        check("midrst_busy_len", n, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
